// File: rtl/wbu_pkg.sv
// wbu_pkg: character constants and the shared six-bit decode/encode table
package wbu_pkg;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_UA  = 8'h41;
    localparam logic [7:0] CH_LA  = 8'h61;
    localparam logic [7:0] CH_AT  = 8'h40;
    localparam logic [7:0] CH_PCT = 8'h25;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [6:0] NL_CODE = 7'h40;
    localparam logic [5:0] ENC_AT  = 6'd62;
    localparam logic [5:0] ENC_PCT = 6'd63;

    // Returns {valid, newline, value[5:0]}
    function automatic logic [7:0] wbu_decode(input logic [7:0] c, input logic opt_cr);
        logic [7:0] n, u, l;
        n = c - CH_0;
        u = c - CH_UA + 8'd10;
        l = c - CH_LA + 8'd36;
        return (c >= CH_0  && c <= CH_0 + 8'd9)   ? {2'b10, n[5:0]} :
               (c >= CH_UA && c <= CH_UA + 8'd25) ? {2'b10, u[5:0]} :
               (c >= CH_LA && c <= CH_LA + 8'd25) ? {2'b10, l[5:0]} :
               (c == CH_AT)                       ? {2'b10, ENC_AT} :
               (c == CH_PCT)                      ? {2'b10, ENC_PCT} :
               (c == CH_LF || (opt_cr && c == CH_CR)) ? {1'b1, NL_CODE} : 8'h00;
    endfunction

    // Inverse of wbu_decode for the encoder side
    function automatic logic [7:0] wbu_encode(input logic [6:0] w);
        logic [7:0] v;
        v = {2'b00, w[5:0]};
        return w[6]          ? CH_LF :
               (v < 8'd10)   ? CH_0 + v :
               (v < 8'd36)   ? CH_UA + v - 8'd10 :
               (v < 8'd62)   ? CH_LA + v - 8'd36 :
               (v == 8'd62)  ? CH_AT : CH_PCT;
    endfunction
endpackage

// File: rtl/wbufifo2.sv
// wbufifo2: 2-entry valid/busy FIFO with a registered full flag
//   i_clk, i_reset (async high); i_stb/i_data write side; o_full write backpressure;
//   o_stb/o_data head word; i_busy read backpressure
module wbufifo2 #(
    parameter int W = 7
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_stb,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_stb,
    output logic [W-1:0] o_data,
    input  logic         i_busy
);
    logic [1:0]   count;
    logic [W-1:0] mem1;
    logic         wr, rd;

    assign o_full = count[1];
    assign o_stb  = |count;
    assign wr     = i_stb && !o_full;
    assign rd     = o_stb && !i_busy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count  <= 2'd0;
            o_data <= '0;
            mem1   <= '0;
        end else begin
            count <= count + {1'b0, wr} - {1'b0, rd};
            // On a pop the head refills from the second slot, or from the
            // incoming word when only one entry was held
            if (rd)
                o_data <= count[1] ? mem1 : i_data;
            else if (wr && count == 2'd0)
                o_data <= i_data;
            if (wr && count[0] && !rd)
                mem1 <= i_data;
        end
    end
endmodule

// File: rtl/wbucharsix.sv
// wbucharsix: ASCII to six-bit word decoder with 2-deep output buffer
//   i_clk, i_reset (async high); i_stb/i_char/o_busy input handshake;
//   o_stb/o_bits/i_busy output handshake; o_err pulse and saturating o_err_count
module wbucharsix
    import wbu_pkg::*;
#(
    parameter bit OPT_CR_NEWLINE = 1'b0,
    parameter int ERR_WIDTH      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stb,
    input  logic [7:0]           i_char,
    output logic                 o_busy,
    output logic                 o_stb,
    output logic [6:0]           o_bits,
    input  logic                 i_busy,
    output logic                 o_err,
    output logic [ERR_WIDTH-1:0] o_err_count
);
    logic [7:0] dec;
    logic       accept;

    assign accept = i_stb && !o_busy;
    assign dec    = wbu_decode(i_char, OPT_CR_NEWLINE);

    wbufifo2 #(.W(7)) u_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_stb  (accept && dec[7]),
        .i_data (dec[6:0]),
        .o_full (o_busy),
        .o_stb  (o_stb),
        .o_data (o_bits),
        .i_busy (i_busy)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_err       <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_err <= accept && !dec[7];
            if (accept && !dec[7] && !(&o_err_count))
                o_err_count <= o_err_count + 1'b1;
        end
    end
endmodule

// File: doc/wbucharsix.md
WBUCHARSIX -- requirements
Module: wbucharsix

Interface
REQ-001 SHALL have parameter OPT_CR_NEWLINE, default 0, meaning that when 1, 0x0D decodes as newline, and when 0 it is invalid.
REQ-002 SHALL have parameter ERR_WIDTH, default 8, setting the width of the invalid-character counter.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have port i_stb, input, 1 bit: an input ASCII character is valid.
REQ-006 SHALL have port i_char, input, 8 bits: the ASCII character.
REQ-007 SHALL have port o_busy, output, 1 bit: the block cannot accept a character this cycle.
REQ-008 SHALL have port o_stb, output, 1 bit: a decoded word is valid.
REQ-009 SHALL have port o_bits, output, 7 bits: bit 6 is newline; bits 5:0 are the six-bit value.
REQ-010 SHALL have port i_busy, input, 1 bit: downstream cannot accept a word this cycle.
REQ-011 SHALL have port o_err, output, 1 bit: a one-cycle pulse marking that an invalid character was consumed.
REQ-012 SHALL have port o_err_count, output, ERR_WIDTH bits: a saturating count of invalid characters.

Function
REQ-013 SHALL accept an input character on a cycle when i_stb is high and o_busy is low; no other cycle accepts input.
REQ-014 SHALL transfer an output word on a cycle when o_stb is high and i_busy is low; no other cycle transfers output.
REQ-015 SHALL decode '0'-'9' to bits 0-9, 'A'-'Z' to 10-35, 'a'-'z' to 36-61, '@' to 62 and '%' to 63, each with bit 6 = 0.
REQ-016 SHALL decode 0x0A (and 0x0D when OPT_CR_NEWLINE is 1) to 7'h40.
REQ-017 SHALL treat every other i_char value as invalid, including bit 7 set: the character is consumed, nothing is enqueued, and o_err is high on the following cycle only.
REQ-018 SHALL increment o_err_count once per invalid accept and hold it at all-ones on saturation, with no wrap.
REQ-019 SHALL buffer valid words in a 2-entry FIFO, in order, with no loss or duplication.
REQ-020 SHALL drive o_stb high on the cycle after a valid accept into an empty FIFO, with o_bits equal to that decode (1-clock latency).
REQ-021 SHALL keep o_stb and o_bits stable while o_stb is high and i_busy is high.
REQ-022 SHALL hold o_busy equal to FIFO-full (2 entries), registered, and derived from no combinational path from i_busy.
REQ-023 SHALL, on a simultaneous accept and transfer with the FIFO at 1 entry, keep the FIFO at 1 entry, with the new word presented next cycle.
REQ-024 SHALL, on a simultaneous accept and transfer with the FIFO at 2 entries, accept nothing, because o_busy is high.
REQ-025 SHALL, when an invalid character is accepted at the same cycle as a transfer, only decrement the occupancy.
REQ-026 SHALL treat o_bits as don't-care while o_stb is low, but it must not change on cycles without a transfer or an enqueue into an empty FIFO.

Reset
REQ-027 SHALL, while i_reset is high, force immediately: o_stb=0, o_busy=0, o_err=0, o_err_count=0, FIFO empty, o_bits=7'h00.
REQ-028 SHALL, on reset assertion mid-transfer, discard buffered words; the first accept after release behaves as if into an empty FIFO.

Structure
REQ-029 SHALL place the character constants ('0', 'A', 'a', '@', '%', LF, CR) and the newline code 7'h40 in the shared package wbu_pkg, alongside the encoder's constants.
REQ-030 SHALL place the decode mapping in wbu_pkg as a pure function, so that encoder and decoder share one table definition.
REQ-031 SHALL instantiate one sub-module, wbufifo2, a 2-entry valid/busy FIFO with a registered full flag and parameterized width; all other logic is inline.

Verification
REQ-032 SHALL cover: i_char 'Z' (0x5A) accepted, i_busy=0 -> next cycle o_stb=1, o_bits=7'd35; following cycle o_stb=0.
REQ-033 SHALL cover: i_char 0x0A, then '%', then '@' back-to-back, i_busy=0 -> o_bits 7'h40, 7'd63, 7'd62 on consecutive cycles.
REQ-034 SHALL cover: i_busy held high, chars '0','1','2' offered -> o_busy high after the second accept, '2' stalled; release i_busy -> output 0, 1, 2 in order.
REQ-035 SHALL cover: i_char 0x21 '!' then 0x0D (OPT_CR_NEWLINE=0) -> two o_err pulses, o_err_count=2, o_stb never high; with OPT_CR_NEWLINE=1 -> 0x0D yields 7'h40, count=1.
REQ-036 SHALL cover: 300 invalid chars with ERR_WIDTH=8 -> o_err_count saturates at 255.
REQ-037 SHALL cover: FIFO holding 2 words, i_reset pulsed asynchronously mid-cycle -> o_stb=0 and o_busy=0 immediately; a post-reset 'a' -> o_bits=7'd36 one cycle after accept.
